// File: rtl/cpu_run_monitor_if.sv
// Bundle of run-control, core-observation and trace-read signals between the run monitor and its user.
interface cpu_run_monitor_if #(
    parameter int PC_W   = 16,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16
);
    localparam int AW = $clog2(DEPTH);

    logic                     start;
    logic                     cpu_reset;
    logic [PC_W-1:0]          pc_in;
    logic [DATA_W-1:0]        result_in;
    logic [AW-1:0]            rd_addr;
    logic [PC_W+DATA_W-1:0]   rd_data;
    logic [AW:0]              entries;
    logic [31:0]              cycle_count;
    logic [1:0]               state;
    logic                     done;
    logic                     halted;
    logic                     timeout;

    modport master (
        output start, pc_in, result_in, rd_addr,
        input  cpu_reset, rd_data, entries, cycle_count, state, done, halted, timeout
    );

    modport slave (
        input  start, pc_in, result_in, rd_addr,
        output cpu_reset, rd_data, entries, cycle_count, state, done, halted, timeout
    );
endinterface

// File: rtl/cpu_run_monitor.sv
// Run controller for the 16-bit core: sequences its reset, traces PC changes, ends run on halt or timeout.
// rd_data follows rd_addr by one cycle; no backpressure, start is ignored outside IDLE/DONE.
module cpu_run_monitor #(
    parameter int PC_W         = 16,
    parameter int DATA_W       = 16,
    parameter int DEPTH        = 16,
    parameter int RESET_CYCLES = 5,
    parameter int HALT_CYCLES  = 4,
    parameter int MAX_CYCLES   = 1024
) (
    input  logic              clk,
    input  logic              reset,
    cpu_run_monitor_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = AW + 1;
    localparam int TW = PC_W + DATA_W;
    localparam int HW = $clog2(RESET_CYCLES + 1);
    localparam int SW = $clog2(HALT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            cpu_reset_q, cpu_reset_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [SW-1:0]   stable_q, stable_d;
    logic [31:0]     cycle_count_q, cycle_count_d;
    logic [EW-1:0]   entries_q, entries_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PC_W-1:0] prev_pc_q, prev_pc_d;
    logic            halted_q, halted_d;
    logic            timeout_q, timeout_d;
    logic            done_q, done_d;
    logic [TW-1:0]   rd_data_q, rd_data_d;
    logic [TW-1:0]   trace_q [DEPTH];

    logic            wr_en;
    logic            first_run;
    logic            pc_same;
    logic [AW-1:0]   rd_idx;

    always_comb begin
        state_d       = state_q;
        cpu_reset_d   = cpu_reset_q;
        hold_cnt_d    = hold_cnt_q;
        stable_d      = stable_q;
        cycle_count_d = cycle_count_q;
        entries_d     = entries_q;
        wr_ptr_d      = wr_ptr_q;
        halted_d      = halted_q;
        timeout_d     = timeout_q;
        done_d        = done_q;
        prev_pc_d     = bus.pc_in;
        wr_en         = 1'b0;

        // The first RUN cycle always records, whatever PC the core held in reset.
        first_run = (cycle_count_q == '0);
        pc_same   = !first_run && (bus.pc_in == prev_pc_q);

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d       = HOLD;
                    cpu_reset_d   = 1'b1;
                    hold_cnt_d    = '0;
                    stable_d      = '0;
                    cycle_count_d = '0;
                    entries_d     = '0;
                    wr_ptr_d      = '0;
                    halted_d      = 1'b0;
                    timeout_d     = 1'b0;
                    done_d        = 1'b0;
                end
            end
            HOLD: begin
                if (hold_cnt_q == HW'(RESET_CYCLES - 1)) begin
                    state_d     = RUN;
                    cpu_reset_d = 1'b0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (cycle_count_q != '1) begin
                    cycle_count_d = cycle_count_q + 1'b1;
                end
                if (!pc_same) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (entries_q != EW'(DEPTH)) begin
                        entries_d = entries_q + 1'b1;
                    end
                end
                stable_d = pc_same ? stable_q + 1'b1 : '0;
                // Halt takes priority when both end conditions land on the same cycle.
                if (stable_d == SW'(HALT_CYCLES)) begin
                    halted_d    = 1'b1;
                    state_d     = DONE;
                    cpu_reset_d = 1'b1;
                    done_d      = 1'b1;
                end else if (cycle_count_d == 32'(MAX_CYCLES)) begin
                    timeout_d   = 1'b1;
                    state_d     = DONE;
                    cpu_reset_d = 1'b1;
                    done_d      = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Logical index 0 is the oldest entry; once full, the oldest sits at wr_ptr.
        rd_idx    = ((entries_q == EW'(DEPTH)) ? wr_ptr_q : '0) + bus.rd_addr;
        rd_data_d = ({1'b0, bus.rd_addr} < entries_q) ? trace_q[rd_idx] : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cpu_reset_q   <= 1'b1;
            hold_cnt_q    <= '0;
            stable_q      <= '0;
            cycle_count_q <= '0;
            entries_q     <= '0;
            wr_ptr_q      <= '0;
            prev_pc_q     <= '0;
            halted_q      <= 1'b0;
            timeout_q     <= 1'b0;
            done_q        <= 1'b0;
            rd_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            cpu_reset_q   <= cpu_reset_d;
            hold_cnt_q    <= hold_cnt_d;
            stable_q      <= stable_d;
            cycle_count_q <= cycle_count_d;
            entries_q     <= entries_d;
            wr_ptr_q      <= wr_ptr_d;
            prev_pc_q     <= prev_pc_d;
            halted_q      <= halted_d;
            timeout_q     <= timeout_d;
            done_q        <= done_d;
            rd_data_q     <= rd_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            trace_q[wr_ptr_q] <= {bus.pc_in, bus.result_in};
        end
    end

    assign bus.state       = state_q;
    assign bus.cpu_reset   = cpu_reset_q;
    assign bus.entries     = entries_q;
    assign bus.cycle_count = cycle_count_q;
    assign bus.halted      = halted_q;
    assign bus.timeout     = timeout_q;
    assign bus.done        = done_q;
    assign bus.rd_data     = rd_data_q;
endmodule

// File: tb/tb_cpu_run_monitor.sv
// Three monitors (default, short budget, instant halt) driven together and checked against a trace-list model.
module tb_cpu_run_monitor;
    localparam int NI = 3;

    typedef struct packed {
        logic [1:0]  state;
        logic        cpu_reset;
        logic        done;
        logic        halted;
        logic        timeout;
        logic [4:0]  entries;
        logic [31:0] cycle_count;
        logic [31:0] rd_data;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  start_v;
    logic [15:0] pc;
    logic [15:0] res;
    logic [3:0]  rd_addr;

    always #5 clk = ~clk;

    cpu_run_monitor_if #(.PC_W(16), .DATA_W(16), .DEPTH(16)) bus0 ();
    cpu_run_monitor_if #(.PC_W(16), .DATA_W(16), .DEPTH(16)) bus1 ();
    cpu_run_monitor_if #(.PC_W(16), .DATA_W(16), .DEPTH(16)) bus2 ();

    assign bus0.start = start_v[0];
    assign bus1.start = start_v[1];
    assign bus2.start = start_v[2];
    assign bus0.pc_in = pc;
    assign bus1.pc_in = pc;
    assign bus2.pc_in = pc;
    assign bus0.result_in = res;
    assign bus1.result_in = res;
    assign bus2.result_in = res;
    assign bus0.rd_addr = rd_addr;
    assign bus1.rd_addr = rd_addr;
    assign bus2.rd_addr = rd_addr;

    cpu_run_monitor #(.PC_W(16), .DATA_W(16), .DEPTH(16), .RESET_CYCLES(5), .HALT_CYCLES(4), .MAX_CYCLES(1024))
        u0 (.clk(clk), .reset(reset), .bus(bus0));
    cpu_run_monitor #(.PC_W(16), .DATA_W(16), .DEPTH(16), .RESET_CYCLES(5), .HALT_CYCLES(4), .MAX_CYCLES(10))
        u1 (.clk(clk), .reset(reset), .bus(bus1));
    cpu_run_monitor #(.PC_W(16), .DATA_W(16), .DEPTH(16), .RESET_CYCLES(5), .HALT_CYCLES(1), .MAX_CYCLES(2))
        u2 (.clk(clk), .reset(reset), .bus(bus2));

    obs_t dut_o [NI];
    obs_t exp_o [NI];
    assign dut_o[0] = {bus0.state, bus0.cpu_reset, bus0.done, bus0.halted, bus0.timeout,
                       bus0.entries, bus0.cycle_count, bus0.rd_data};
    assign dut_o[1] = {bus1.state, bus1.cpu_reset, bus1.done, bus1.halted, bus1.timeout,
                       bus1.entries, bus1.cycle_count, bus1.rd_data};
    assign dut_o[2] = {bus2.state, bus2.cpu_reset, bus2.done, bus2.halted, bus2.timeout,
                       bus2.entries, bus2.cycle_count, bus2.rd_data};

    int n_checks = 0;
    int n_err    = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: trace kept as an ordered list, oldest first, shifted when full.
    int          halt_p [NI] = '{4, 4, 1};
    int          max_p  [NI] = '{1024, 10, 2};
    int          m_st   [NI];
    int          m_hold [NI];
    int          m_stab [NI];
    int          m_n    [NI];
    logic [31:0] m_cnt  [NI];
    logic [15:0] m_prev [NI];
    logic        m_halt [NI];
    logic        m_to   [NI];
    logic        m_crst [NI];
    logic [31:0] m_rd   [NI];
    logic [31:0] m_tr   [NI][16];
    bit          m_first;
    bit          m_same;

    task automatic push(input int k, input logic [31:0] v);
        if (m_n[k] < 16) begin
            m_tr[k][m_n[k]] = v;
            m_n[k]++;
        end else begin
            for (int i = 0; i < 15; i++) m_tr[k][i] = m_tr[k][i+1];
            m_tr[k][15] = v;
        end
    endtask

    task automatic end_run(input int k);
        m_st[k]   = 3;
        m_crst[k] = 1'b1;
    endtask

    initial forever begin
        @(posedge clk);
        for (int k = 0; k < NI; k++) begin
            m_rd[k] = (int'(rd_addr) < m_n[k]) ? m_tr[k][rd_addr] : 32'h0;
            if (reset) begin
                m_st[k] = 0; m_hold[k] = 0; m_stab[k] = 0; m_n[k] = 0; m_cnt[k] = 0;
                m_halt[k] = 1'b0; m_to[k] = 1'b0; m_crst[k] = 1'b1; m_rd[k] = 32'h0;
            end else if (start_v[k] && (m_st[k] == 0 || m_st[k] == 3)) begin
                m_st[k] = 1; m_hold[k] = 0; m_stab[k] = 0; m_n[k] = 0; m_cnt[k] = 0;
                m_halt[k] = 1'b0; m_to[k] = 1'b0; m_crst[k] = 1'b1;
            end else if (m_st[k] == 1) begin
                m_hold[k]++;
                if (m_hold[k] == 5) begin
                    m_st[k]   = 2;
                    m_crst[k] = 1'b0;
                end
            end else if (m_st[k] == 2) begin
                m_first = (m_cnt[k] == 0);
                m_same  = !m_first && (pc == m_prev[k]);
                if (m_cnt[k] != 32'hffff_ffff) m_cnt[k]++;
                if (!m_same) push(k, {pc, res});
                m_stab[k] = m_same ? m_stab[k] + 1 : 0;
                if (m_stab[k] == halt_p[k]) begin
                    m_halt[k] = 1'b1;
                    end_run(k);
                end else if (m_cnt[k] == 32'(max_p[k])) begin
                    m_to[k] = 1'b1;
                    end_run(k);
                end
            end
            m_prev[k] = pc;
            exp_o[k] = {2'(m_st[k]), m_crst[k], (m_st[k] == 3), m_halt[k], m_to[k],
                        5'(m_n[k]), m_cnt[k], m_rd[k]};
        end
    end

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            for (int k = 0; k < NI; k++) check($sformatf("model u%0d", k), dut_o[k], exp_o[k]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int k);
        start_v[k] = 1'b1;
        step();
        start_v[k] = 1'b0;
    endtask

    task automatic wait_run(input int k);
        bit ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dut_o[k].state == 2'd2) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_err++;
            $display("FAIL wait_run u%0d: state %0d, required 2", k, dut_o[k].state);
        end
    endtask

    initial begin
        reset = 1'b1; start_v = '0; pc = '0; res = '0; rd_addr = '0;
        repeat (3) step();
        cmp_en = 1'b1;
        @(negedge clk);
        check("reset state", bus0.state, 0);
        check("reset cpu_reset", bus0.cpu_reset, 1);
        check("reset entries", bus0.entries, 0);
        check("reset rd_data", bus0.rd_data, 0);
        reset = 1'b0;

        // Reset sequencing: five HOLD cycles, then RUN with the core released.
        pulse(0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold state", bus0.state, 1);
            check("hold cpu_reset", bus0.cpu_reset, 1);
            step();
        end
        @(negedge clk);
        check("run state", bus0.state, 2);
        check("run cpu_reset", bus0.cpu_reset, 0);

        // PC 0,1,2,3 then stuck at 3: halt after four stable cycles.
        for (int i = 0; i < 8; i++) begin
            pc  = 16'((i < 4) ? i : 3);
            res = 16'($urandom);
            step();
        end
        @(negedge clk);
        check("halt state", bus0.state, 3);
        check("halt done", bus0.done, 1);
        check("halt halted", bus0.halted, 1);
        check("halt timeout", bus0.timeout, 0);
        check("halt entries", bus0.entries, 4);
        check("halt cycle_count", bus0.cycle_count, 8);
        rd_addr = 4'd2;
        step();
        @(negedge clk);
        check("read idx2 pc", bus0.rd_data[31:16], 2);
        rd_addr = 4'd5;
        step();
        @(negedge clk);
        check("read past entries", bus0.rd_data, 0);

        // Relaunch from DONE, then wrap the trace with 20 distinct PCs.
        pulse(0);
        @(negedge clk);
        check("relaunch state", bus0.state, 1);
        check("relaunch entries", bus0.entries, 0);
        check("relaunch cycle_count", bus0.cycle_count, 0);
        check("relaunch halted", bus0.halted, 0);
        wait_run(0);
        for (int i = 0; i < 24; i++) begin
            pc  = 16'((i < 20) ? i : 19);
            res = 16'($urandom);
            step();
        end
        @(negedge clk);
        check("wrap entries", bus0.entries, 16);
        rd_addr = 4'd0;
        step();
        @(negedge clk);
        check("wrap oldest pc", bus0.rd_data[31:16], 4);
        rd_addr = 4'd15;
        step();
        @(negedge clk);
        check("wrap newest pc", bus0.rd_data[31:16], 19);

        // Cycle budget of 10 with a constantly moving PC.
        pulse(1);
        wait_run(1);
        for (int i = 0; i < 10; i++) begin
            pc = 16'(100 + i);
            step();
        end
        @(negedge clk);
        check("budget timeout", bus1.timeout, 1);
        check("budget halted", bus1.halted, 0);
        check("budget cycle_count", bus1.cycle_count, 10);
        check("budget cpu_reset", bus1.cpu_reset, 1);

        // Halt and timeout on the same cycle: halt wins.
        pulse(2);
        wait_run(2);
        pc = 16'd7;
        step();
        step();
        @(negedge clk);
        check("tie halted", bus2.halted, 1);
        check("tie timeout", bus2.timeout, 0);
        check("tie cycle_count", bus2.cycle_count, 2);

        // start ignored in RUN, then reset aborts the run.
        pulse(0);
        wait_run(0);
        for (int i = 0; i < 3; i++) begin
            pc = 16'(200 + i);
            step();
        end
        pulse(0);
        @(negedge clk);
        check("start in run", bus0.state, 2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        check("abort state", bus0.state, 0);
        check("abort entries", bus0.entries, 0);
        check("abort cpu_reset", bus0.cpu_reset, 1);

        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            for (int k = 0; k < NI; k++) start_v[k] = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 2) != 0) pc = 16'($urandom_range(0, 31));
            res     = 16'($urandom);
            rd_addr = 4'($urandom);
            step();
        end
        start_v = '0;
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
